// File: rtl/zom_pkg.sv
// Shared types and constants for the zombie spawn dispatcher.
package zom_pkg;
  localparam int N_SLOTS_MAX = 15;

  typedef logic [3:0] slot_idx_t;
  typedef logic [2:0] row_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;

  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/zom_lfsr8.sv
// 8-bit Galois LFSR used to pick spawn rows. Holds when en=0.
module zom_lfsr8 import zom_pkg::*; (
  input  logic       clk,
  input  logic       Reset,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] q_q, q_d;

  // Shift right; fold the feedback mask in when a one falls out of bit 0.
  always_comb begin
    q_d = q_q;
    if (en) q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_TAPS) : (q_q >> 1);
  end

  // State register; a non-zero seed keeps the sequence off the all-zero lockup.
  always_ff @(posedge clk) begin
    if (Reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/zom_spawn_dispatcher.sv
// Zombie slot owner: decides when/where zombies spawn, frees slots on kills,
// and drives per-slot enable, launch pulse and row to the instance array.
module zom_spawn_dispatcher import zom_pkg::*; #(
  parameter int         N_SLOTS      = 10,
  parameter int         N_ROWS       = 5,
  parameter int         SPAWN_PERIOD = 120,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   game_run,
  input  logic                   spawn_req,
  input  logic                   kill_valid,
  input  logic [3:0]             kill_slot,
  output logic                   kill_ack,
  output logic                   kill_err,
  output logic [N_SLOTS-1:0]     slot_active,
  output logic [N_SLOTS-1:0]     spawn_pulse,
  output logic [3*N_SLOTS-1:0]   slot_row,
  output logic [3:0]             active_count,
  output logic                   full
);
  localparam int            TW     = $clog2(SPAWN_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(SPAWN_PERIOD - 1);

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   pending_q, pending_d;
  logic [N_SLOTS-1:0]     slot_active_q, slot_active_d;
  logic [N_SLOTS-1:0]     spawn_pulse_q, spawn_pulse_d;
  logic [3*N_SLOTS-1:0]   slot_row_q, slot_row_d;
  logic                   kill_ack_q, kill_ack_d;
  logic                   kill_err_q, kill_err_d;

  logic [7:0]             lfsr_q;
  logic                   trigger;
  logic [1:0]             n_req;
  logic [N_SLOTS-1:0]     free_oh;
  logic                   free_found;
  logic [N_SLOTS-1:0]     kill_oh;
  logic                   kill_ok;
  row_t                   new_row;
  logic [3:0]             cnt;

  zom_lfsr8 u_lfsr (
    .clk   (MAX10_CLK1_50),
    .Reset (Reset),
    .en    (state_q == S_RUN),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // FSM state register.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: IDLE -> RUN while game runs, RUN -> CLEAR when it stops, CLEAR -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (game_run)  state_d = S_RUN;
      S_RUN:   if (!game_run) state_d = S_CLEAR;
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame-tick timer; the wrap cycle raises the automatic spawn trigger.
  always_comb begin
    timer_d = timer_q;
    trigger = 1'b0;
    if (state_q == S_CLEAR) begin
      timer_d = '0;
    end else if (state_q == S_RUN && frame_tick) begin
      if (timer_q == T_LAST) begin
        timer_d = '0;
        trigger = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Lowest free slot as one-hot: ~a & (a+1) isolates the lowest zero bit.
  // Uses the registered vector, so a slot freed this cycle is not reused until next.
  always_comb begin
    free_oh    = ~slot_active_q & (slot_active_q + 1'b1);
    free_found = |free_oh;
  end

  // Kill decode; out-of-range indices match nothing and therefore report an error.
  always_comb begin
    kill_oh = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (kill_slot == slot_idx_t'(i)) kill_oh[i] = 1'b1;
    kill_ok = kill_valid && |(kill_oh & slot_active_q);
  end

  // Outstanding requests this cycle; anything beyond the one served spills into pending.
  always_comb begin
    n_req   = 2'(trigger) + 2'(spawn_req) + 2'(pending_q);
    new_row = row_t'(lfsr_q % 8'(N_ROWS));
  end

  // FSM outputs: allocation, kill handling and the CLEAR wipe.
  always_comb begin
    slot_active_d = slot_active_q;
    slot_row_d    = slot_row_q;
    spawn_pulse_d = '0;
    pending_d     = pending_q;
    kill_ack_d    = 1'b0;
    kill_err_d    = 1'b0;
    case (state_q)
      S_IDLE: kill_err_d = kill_valid;
      S_RUN: begin
        if (n_req != 2'd0) begin
          if (free_found) begin
            slot_active_d = slot_active_q | free_oh;
            spawn_pulse_d = free_oh;
            for (int i = 0; i < N_SLOTS; i++)
              if (free_oh[i]) slot_row_d[3*i +: 3] = new_row;
            pending_d = (n_req >= 2'd2);
          end else begin
            pending_d = 1'b1;
          end
        end
        if (kill_valid) begin
          if (kill_ok) begin
            slot_active_d = slot_active_d & ~kill_oh;
            kill_ack_d    = 1'b1;
          end else begin
            kill_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        slot_active_d = '0;
        slot_row_d    = '0;
        pending_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset wins over everything, including in-flight pulses.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (Reset) begin
      timer_q       <= '0;
      pending_q     <= 1'b0;
      slot_active_q <= '0;
      spawn_pulse_q <= '0;
      slot_row_q    <= '0;
      kill_ack_q    <= 1'b0;
      kill_err_q    <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      slot_active_q <= slot_active_d;
      spawn_pulse_q <= spawn_pulse_d;
      slot_row_q    <= slot_row_d;
      kill_ack_q    <= kill_ack_d;
      kill_err_q    <= kill_err_d;
    end
  end

  // Popcount of occupied slots.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) cnt = cnt + 4'(slot_active_q[i]);
  end

  assign slot_active  = slot_active_q;
  assign spawn_pulse  = spawn_pulse_q;
  assign slot_row     = slot_row_q;
  assign kill_ack     = kill_ack_q;
  assign kill_err     = kill_err_q;
  assign active_count = cnt;
  assign full         = (cnt == 4'(N_SLOTS));
endmodule

// File: tb/tb_zom_spawn_dispatcher.sv
// Bench for zom_spawn_dispatcher: directed stimulus, a slot-level behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_zom_spawn_dispatcher;
  localparam int NS = 10;
  localparam int NR = 5;
  localparam int P  = 4;

  logic clk = 1'b0;
  logic rst, frame_tick, game_run, spawn_req, kill_valid;
  logic [3:0] kill_slot;
  logic kill_ack, kill_err, full;
  logic [NS-1:0] slot_active, spawn_pulse;
  logic [3*NS-1:0] slot_row;
  logic [3:0] active_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  zom_spawn_dispatcher #(.N_SLOTS(NS), .N_ROWS(NR), .SPAWN_PERIOD(P), .LFSR_SEED(8'hA5)) dut (
    .MAX10_CLK1_50 (clk),
    .Reset         (rst),
    .frame_tick    (frame_tick),
    .game_run      (game_run),
    .spawn_req     (spawn_req),
    .kill_valid    (kill_valid),
    .kill_slot     (kill_slot),
    .kill_ack      (kill_ack),
    .kill_err      (kill_err),
    .slot_active   (slot_active),
    .spawn_pulse   (spawn_pulse),
    .slot_row      (slot_row),
    .active_count  (active_count),
    .full          (full)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_state;          // 0 idle, 1 running, 2 clearing
  bit       m_active [NS];
  int       m_row    [NS];
  bit       m_pulse  [NS];
  bit       m_pending, m_ack, m_err, m_valid;
  int       m_timer;
  bit [7:0] m_lfsr;
  bit       pre [NS];
  bit       trig;
  int       nreq, fi, ks;

  function automatic bit [7:0] lfsr_next(input bit [7:0] v);
    // x^8+x^6+x^5+x^4+1, Galois right-shift
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pending = 0; m_timer = 0; m_lfsr = 8'hA5;
      m_ack = 0; m_err = 0; m_valid = 1;
      for (int i = 0; i < NS; i++) begin m_active[i] = 0; m_row[i] = 0; m_pulse[i] = 0; end
    end else if (m_valid) begin
      m_ack = 0; m_err = 0;
      for (int i = 0; i < NS; i++) m_pulse[i] = 0;
      case (m_state)
        0: begin
          if (kill_valid) m_err = 1;
          if (game_run) m_state = 1;
        end
        1: begin
          pre  = m_active;
          trig = frame_tick && (m_timer == P - 1);
          if (frame_tick) m_timer = trig ? 0 : m_timer + 1;
          nreq = int'(trig) + int'(spawn_req) + int'(m_pending);
          fi = -1;
          for (int i = NS - 1; i >= 0; i--) if (!pre[i]) fi = i;
          if (nreq > 0) begin
            if (fi >= 0) begin
              m_active[fi] = 1; m_pulse[fi] = 1; m_row[fi] = int'(m_lfsr) % NR;
              m_pending = (nreq >= 2);
            end else m_pending = 1;
          end
          if (kill_valid) begin
            ks = int'(kill_slot);
            if (ks < NS && pre[ks]) begin m_active[ks] = 0; m_ack = 1; end
            else m_err = 1;
          end
          m_lfsr = lfsr_next(m_lfsr);
          if (!game_run) m_state = 2;
        end
        default: begin
          for (int i = 0; i < NS; i++) begin m_active[i] = 0; m_row[i] = 0; end
          m_pending = 0; m_timer = 0; m_state = 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NS-1:0]   e_act, e_pul;
  logic [3*NS-1:0] e_row;
  int              e_cnt;

  always @(negedge clk) begin
    if (m_valid) begin
      e_cnt = 0;
      for (int i = 0; i < NS; i++) begin
        e_act[i] = m_active[i];
        e_pul[i] = m_pulse[i];
        e_row[3*i +: 3] = 3'(m_row[i]);
        e_cnt += int'(m_active[i]);
      end
      chk("model_active", 32'(slot_active), 32'(e_act));
      chk("model_pulse",  32'(spawn_pulse), 32'(e_pul));
      chk("model_row",    32'(slot_row),    32'(e_row));
      chk("model_count",  32'(active_count), 32'(e_cnt));
      chk("model_full",   32'(full),     32'(e_cnt == NS));
      chk("model_ack",    32'(kill_ack), 32'(m_ack));
      chk("model_err",    32'(kill_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; frame_tick = 0; game_run = 0; spawn_req = 0; kill_valid = 0; kill_slot = 0;
    cyc(); cyc();
    chk("rst_active", 32'(slot_active), 32'h0);
    chk("rst_count",  32'(active_count), 32'h0);
    chk("rst_pulse",  32'(spawn_pulse), 32'h0);
    chk("rst_row",    32'(slot_row), 32'h0);
    rst = 0;

    // periodic spawn after P ticks
    game_run = 1; cyc();
    frame_tick = 1; repeat (3) cyc();
    chk("pre_trig_active", 32'(slot_active), 32'h0);
    cyc();
    chk("trig_active", 32'(slot_active), 32'h001);
    chk("trig_pulse",  32'(spawn_pulse), 32'h001);
    chk("trig_count",  32'(active_count), 32'd1);
    chk("trig_row_lt5", 32'(slot_row[2:0] < 3'd5), 32'd1);
    frame_tick = 0; cyc();
    chk("pulse_one_cycle", 32'(spawn_pulse), 32'h0);

    // fill the remaining slots, then one more request while full
    spawn_req = 1; repeat (9) cyc();
    chk("fill_active", 32'(slot_active), 32'h3FF);
    chk("fill_full",   32'(full), 32'd1);
    chk("fill_count",  32'(active_count), 32'd10);
    cyc();
    chk("full_no_pulse", 32'(spawn_pulse), 32'h0);
    spawn_req = 0;

    // kill slot 3; pending request then lands in slot 3
    kill_valid = 1; kill_slot = 4'd3; cyc();
    chk("kill3_ack",    32'(kill_ack), 32'd1);
    chk("kill3_active", 32'(slot_active), 32'h3F7);
    kill_valid = 0; cyc();
    chk("realloc3_pulse", 32'(spawn_pulse), 32'h008);
    chk("realloc3_full",  32'(full), 32'd1);

    // kill 7 twice (second is inactive), then out-of-range 12, then slot 0
    kill_valid = 1; kill_slot = 4'd7; cyc();
    chk("kill7_ack", 32'(kill_ack), 32'd1);
    cyc();
    chk("kill7_again_err", 32'(kill_err), 32'd1);
    chk("kill7_again_act", 32'(slot_active), 32'h37F);
    kill_slot = 4'd12; cyc();
    chk("kill12_err", 32'(kill_err), 32'd1);
    chk("kill12_act", 32'(slot_active), 32'h37F);
    kill_slot = 4'd0; cyc();
    chk("kill0_act", 32'(slot_active), 32'h37E);
    kill_valid = 0;

    // trigger and spawn_req together: two allocations on consecutive cycles
    frame_tick = 1; repeat (3) cyc();
    spawn_req = 1; cyc();
    chk("dual_first_pulse", 32'(spawn_pulse), 32'h001);
    frame_tick = 0; spawn_req = 0; cyc();
    chk("dual_second_pulse", 32'(spawn_pulse), 32'h080);
    chk("dual_full", 32'(full), 32'd1);

    // stop the game: one CLEAR cycle, then empty
    game_run = 0; cyc();
    chk("clear_entry_act", 32'(slot_active), 32'h3FF);
    cyc();
    chk("clear_active", 32'(slot_active), 32'h0);
    chk("clear_count",  32'(active_count), 32'd0);
    kill_valid = 1; kill_slot = 4'd2; spawn_req = 1; cyc();
    chk("idle_kill_err", 32'(kill_err), 32'd1);
    chk("idle_no_pulse", 32'(spawn_pulse), 32'h0);
    kill_valid = 0; spawn_req = 0;

    // three slots active, then stop
    game_run = 1; cyc();
    spawn_req = 1; repeat (3) cyc(); spawn_req = 0;
    chk("three_count", 32'(active_count), 32'd3);
    chk("three_active", 32'(slot_active), 32'h007);
    game_run = 0; cyc(); cyc();
    chk("three_clear_act", 32'(slot_active), 32'h0);
    chk("three_clear_cnt", 32'(active_count), 32'd0);

    // reset overrides a same-cycle spawn request and kills an in-flight pulse
    game_run = 1; cyc();
    spawn_req = 1; rst = 1; cyc();
    chk("rst_req_pulse", 32'(spawn_pulse), 32'h0);
    chk("rst_req_act",   32'(slot_active), 32'h0);
    rst = 0; spawn_req = 0; cyc();
    spawn_req = 1; cyc();
    spawn_req = 0; rst = 1; cyc();
    chk("rst_after_req_pulse", 32'(spawn_pulse), 32'h0);
    chk("rst_after_req_cnt",   32'(active_count), 32'd0);
    rst = 0; game_run = 0; cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
